way_arbiter_4: RTL and testbench

Round-robin arbiter that shares one 4-input datapath mux, and the resource behind it, between four requesters, e.g. the four ways of the 4-way set-associative cache competing for the fill/writeback path. It produces registered one-hot grants that drive the mux select lines directly. A grant is held until the owner signals completion or drops its request, so the mux select is never changed mid-transfer. An optional watchdog forcibly reclaims a stuck grant.

---
 rtl/way_arbiter_pkg.sv | 18 +
 rtl/rr_pick4.sv | 38 +++
 rtl/way_arbiter_4.sv | 167 ++++++++++++++++
 tb/tb_way_arbiter_4.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/way_arbiter_pkg.sv
// Shared types and sizes for the four-way round-robin arbiter.
//   REQ_COUNT   : number of requesters sharing the datapath mux
//   ID_W        : width of a requester index
//   arb_state_t : arbiter FSM states
//   req_id_t    : binary requester index (0 = A .. 3 = D)
package way_arbiter_pkg;

  localparam int unsigned REQ_COUNT = 4;
  localparam int unsigned ID_W      = 2;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  typedef logic [ID_W-1:0] req_id_t;

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin pick: first set request bit searching from ptr upward, mod 4.
//   req_i   : request vector, bit 0 = A
//   ptr_i   : highest-priority candidate index
//   pick_o  : one-hot winner (zero when nothing requests)
//   id_o    : binary winner index (meaningful only when valid_o)
//   valid_o : at least one request is set
module rr_pick4
  import way_arbiter_pkg::*;
(
  input  logic [REQ_COUNT-1:0] req_i,
  input  req_id_t              ptr_i,
  output logic [REQ_COUNT-1:0] pick_o,
  output req_id_t              id_o,
  output logic                 valid_o
);

  logic [2*REQ_COUNT-1:0] req_dbl;
  logic [REQ_COUNT-1:0]   req_rot;
  req_id_t                first_rot;

  // Rotate so that bit 0 of req_rot is the requester at ptr.
  assign req_dbl = {req_i, req_i};
  assign req_rot = req_dbl[3'(ptr_i) +: REQ_COUNT];

  // Lowest set bit of the rotated vector.
  always_comb begin
    first_rot = '0;
    for (int i = REQ_COUNT - 1; i >= 0; i--) begin
      if (req_rot[i]) first_rot = ID_W'(i);
    end
  end

  // Rotate the index back; 2-bit addition wraps mod 4.
  assign id_o    = first_rot + ptr_i;
  assign valid_o = |req_i;
  assign pick_o  = valid_o ? (REQ_COUNT'(1) << id_o) : '0;

endmodule

// File: rtl/way_arbiter_4.sv
// Round-robin arbiter for one shared 4-input mux. Grants are registered one-hot
// and held until the owner pulses i_done or withdraws its request; every release
// is followed by one idle cycle before the next owner is selected.
// Optional watchdog (macro WAY_ARBITER_4_TIMEOUT_EN) revokes a grant held for
// TIMEOUT_CYCLES cycles and pulses o_timeout in the cycle o_gnt clears.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_req          : per-requester request, bit 0 = A
//   i_done         : owner finished (single-cycle pulse)
//   o_gnt          : registered one-hot grant / mux select, or zero
//   o_gnt_id       : binary owner index, 0 when idle
//   o_busy         : a grant is active
//   o_timeout      : watchdog revoke pulse (only with the macro)
module way_arbiter_4
  import way_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [REQ_COUNT-1:0] i_req,
  input  logic                 i_done,
  output logic [REQ_COUNT-1:0] o_gnt,
  output req_id_t              o_gnt_id,
  output logic                 o_busy
`ifdef WAY_ARBITER_4_TIMEOUT_EN
  ,
  output logic                 o_timeout
`endif
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("way_arbiter_4: TIMEOUT_CYCLES must be within 2..255");
  end

  arb_state_t           state_q, state_d;
  req_id_t              ptr_q, ptr_d;
  logic [REQ_COUNT-1:0] gnt_q, gnt_d;
  req_id_t              id_q, id_d;
  logic                 busy_q, busy_d;

  logic [REQ_COUNT-1:0] pick_c;
  req_id_t              pick_id_c;
  logic                 pick_valid_c;
  logic                 rel_norm_c;
  logic                 release_c;

  rr_pick4 u_pick (
    .req_i   (i_req),
    .ptr_i   (ptr_q),
    .pick_o  (pick_c),
    .id_o    (pick_id_c),
    .valid_o (pick_valid_c)
  );

  // Normal release: owner done or owner withdrew (both together count once).
  assign rel_norm_c = i_done | ~i_req[id_q];

`ifdef WAY_ARBITER_4_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tmo_q, tmo_d;
  logic             wd_fire_c;

  // Fires on the last permitted GRANT cycle; a normal release wins.
  assign wd_fire_c = ~rel_norm_c && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign release_c = rel_norm_c | wd_fire_c;
`else
  assign release_c = rel_norm_c;
`endif

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= ARB_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB_IDLE:  if (pick_valid_c) state_d = ARB_GRANT;
      ARB_GRANT: if (release_c)    state_d = ARB_IDLE;
      default:   state_d = ARB_IDLE;
    endcase
  end

  // Next values for the pointer, output registers and watchdog.
  always_comb begin
    ptr_d  = ptr_q;
    gnt_d  = gnt_q;
    id_d   = id_q;
    busy_d = busy_q;
`ifdef WAY_ARBITER_4_TIMEOUT_EN
    cnt_d  = cnt_q;
    tmo_d  = 1'b0;
`endif
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_valid_c) begin
          gnt_d  = pick_c;
          id_d   = pick_id_c;
          busy_d = 1'b1;
          ptr_d  = pick_id_c + ID_W'(1);
`ifdef WAY_ARBITER_4_TIMEOUT_EN
          cnt_d  = '0;
`endif
        end
      end
      ARB_GRANT: begin
        if (release_c) begin
          gnt_d  = '0;
          id_d   = '0;
          busy_d = 1'b0;
`ifdef WAY_ARBITER_4_TIMEOUT_EN
          cnt_d  = '0;
          tmo_d  = wd_fire_c;
`endif
        end else begin
`ifdef WAY_ARBITER_4_TIMEOUT_EN
          cnt_d  = cnt_q + CNT_W'(1);
`endif
        end
      end
      default: begin
        gnt_d  = '0;
        id_d   = '0;
        busy_d = 1'b0;
      end
    endcase
  end

  // Pointer and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr_q  <= '0;
      gnt_q  <= '0;
      id_q   <= '0;
      busy_q <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      gnt_q  <= gnt_d;
      id_q   <= id_d;
      busy_q <= busy_d;
    end
  end

`ifdef WAY_ARBITER_4_TIMEOUT_EN
  // Watchdog counter and revoke pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
    end
  end

  assign o_timeout = tmo_q;
`endif

  assign o_gnt    = gnt_q;
  assign o_gnt_id = id_q;
  assign o_busy   = busy_q;

endmodule

// File: tb/tb_way_arbiter_4.sv
// Directed bench for way_arbiter_4 with a queue of expected outputs per cycle.
module tb_way_arbiter_4;
  import way_arbiter_pkg::*;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic [3:0] i_req;
  logic       i_done;
  logic [3:0] o_gnt;
  req_id_t    o_gnt_id;
  logic       o_busy;
`ifdef WAY_ARBITER_4_TIMEOUT_EN
  logic       o_timeout;
`endif

  way_arbiter_4 #(.TIMEOUT_CYCLES(4)) dut (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_req    (i_req),
    .i_done   (i_done),
    .o_gnt    (o_gnt),
    .o_gnt_id (o_gnt_id),
    .o_busy   (o_busy)
`ifdef WAY_ARBITER_4_TIMEOUT_EN
    ,
    .o_timeout(o_timeout)
`endif
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [3:0] gnt;
    logic [1:0] id;
    logic       busy;
    logic       tmo;
    string      tag;
  } exp_t;

  exp_t        sb[$];
  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  task automatic push(input logic [3:0] eg, input logic [1:0] eid, input logic eb,
                      input logic et, input string tag);
    exp_t e;
    e.gnt  = eg;
    e.id   = eid;
    e.busy = eb;
    e.tmo  = et;
    e.tag  = tag;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      miscompares++;
      $error("FAIL sb_empty: no expected entry queued");
      return;
    end
    e = sb.pop_front();
    vectors++;
    assert ({o_gnt, o_gnt_id, o_busy} === {e.gnt, e.id, e.busy})
    else begin
      miscompares++;
      $error("FAIL %s: gnt/id/busy got %b/%0d/%b want %b/%0d/%b",
             e.tag, o_gnt, o_gnt_id, o_busy, e.gnt, e.id, e.busy);
    end
    vectors++;
    assert ($onehot0(o_gnt))
    else begin
      miscompares++;
      $error("FAIL %s_onehot: gnt got %b want at most one bit", e.tag, o_gnt);
    end
`ifdef WAY_ARBITER_4_TIMEOUT_EN
    vectors++;
    assert (o_timeout === e.tmo)
    else begin
      miscompares++;
      $error("FAIL %s_tmo: timeout got %b want %b", e.tag, o_timeout, e.tmo);
    end
`endif
  endtask

  // Drive one cycle of inputs, queue the outputs expected after the next edge.
  task automatic step(input logic [3:0] req, input logic done, input logic [3:0] eg,
                      input logic [1:0] eid, input logic eb, input logic et,
                      input string tag);
    i_req  = req;
    i_done = done;
    push(eg, eid, eb, et, tag);
    @(posedge i_clk);
    #1;
    check_out();
  endtask

  task automatic do_reset(input string tag);
    i_rst_n = 1'b0;
    i_req   = '0;
    i_done  = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    push(4'b0000, 2'd0, 1'b0, 1'b0, tag);
    check_out();
    @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] g;
    logic [1:0] gid;

    do_reset("reset");

    // Single requester C, then done; ptr becomes 3 so D wins over A next.
    step(4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0, "t1_grant_c");
    step(4'b0100, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, "t1_release");
    step(4'b1001, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0, "t1_ptr3_d");
    step(4'b1001, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, "t1_release_d");

    // All four requesting: A,B,C,D,A with one idle cycle between owners.
    do_reset("t2_reset");
    for (int k = 0; k < 5; k++) begin
      gid = 2'(k % 4);
      g   = 4'b0001 << gid;
      step(4'b1111, 1'b0, g, gid, 1'b1, 1'b0, "t2_grant");
      step(4'b1111, 1'b0, g, gid, 1'b1, 1'b0, "t2_hold");
      if (k < 4) step(4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, "t2_dead");
    end
    step(4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, "t2_release");

    // B withdraws while A and C wait: release, then C (ptr=2) rather than A.
    step(4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0, "t3_grant_b");
    step(4'b0101, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, "t3_b_drop");
    step(4'b0101, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0, "t3_grant_c");
    step(4'b0101, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, "t3_release_c");

    // Done while idle is ignored; non-owner requests do not disturb a grant.
    step(4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, "t4_idle_done1");
    step(4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, "t4_idle_done2");
    step(4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0, "t4_grant_a");
    step(4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0, "t4_others_all");
    step(4'b1011, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0, "t4_others_bd");
    step(4'b1110, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, "t4_done_and_drop");
    step(4'b1110, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0, "t4_grant_b");
    step(4'b1110, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, "t4_release_b");
    step(4'b1100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0, "t4_grant_c");
    step(4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, "t4_release_c");

    // Asynchronous reset mid-grant clears outputs at once; ptr restarts at 0.
    step(4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0, "t5_grant_d");
    #2;
    i_rst_n = 1'b0;
    #1;
    push(4'b0000, 2'd0, 1'b0, 1'b0, "t5_async_rst");
    check_out();
    @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    step(4'b1010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0, "t5_grant_b");
    step(4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, "t5_release_b");

    // D granted with no done; A also requesting.
    step(4'b1001, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0, "t6_grant_d");
    for (int k = 0; k < 3; k++)
      step(4'b1001, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0, "t6_hold");
`ifdef WAY_ARBITER_4_TIMEOUT_EN
    step(4'b1001, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b1, "t6_timeout");
    step(4'b1001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0, "t6_next_a");
    step(4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, "t6_release_a");
    // Done on the watchdog's final cycle wins: no timeout pulse.
    step(4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0, "t7_grant_b");
    for (int k = 0; k < 3; k++)
      step(4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0, "t7_hold");
    step(4'b0010, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, "t7_done_wins");
    step(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, "t7_idle");
`else
    for (int k = 0; k < 4; k++)
      step(4'b1001, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0, "t6_held_no_wd");
    step(4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, "t6_release_d");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
